// File: rtl/tilt_dir_decoder_if.sv
// Signal bundle between the G-sensor readout stage and the tilt direction decoder.
// The readout side drives the raw bytes, the decoder returns the heading and averaged tilt.
interface tilt_dir_decoder_if;
  logic [7:0]  iX_L;
  logic [7:0]  iX_H;
  logic [7:0]  iY_L;
  logic [7:0]  iY_H;
  logic [1:0]  oDIR;
  logic        oDIR_VALID;
  logic [15:0] oTILT_X;
  logic [15:0] oTILT_Y;
  logic        oFLAT;

  modport master (
    output iX_L, iX_H, iY_L, iY_H,
    input  oDIR, oDIR_VALID, oTILT_X, oTILT_Y, oFLAT
  );

  modport slave (
    input  iX_L, iX_H, iY_L, iY_H,
    output oDIR, oDIR_VALID, oTILT_X, oTILT_Y, oFLAT
  );
endinterface

// File: rtl/tilt_dir_decoder.sv
// Turns raw accelerometer X/Y bytes into a debounced snake heading (sample, 4-tap average,
// dominant axis vs threshold, stability debounce). Define TILT_NO_REVERSE_EN to block 180-degree turns.
module tilt_dir_decoder #(
  parameter int unsigned SAMPLE_DIV = 40000,
  parameter int unsigned THRESH     = 64,
  parameter int unsigned STABLE_N   = 3,
  parameter logic [1:0]  INIT_DIR   = 2'd1
) (
  input  logic            iCLK,
  input  logic            iRST,
  tilt_dir_decoder_if.slave bus
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned SMP_W  = 16;
  localparam int unsigned SUM_W  = 18;
  localparam int unsigned MAG_W  = 17;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CAND_W = 3;
  localparam int unsigned TAPS   = 4;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [MAG_W-1:0]  THRESH_MAG = MAG_W'(THRESH);
  localparam logic [CNT_W-1:0]  STABLE_CNT = CNT_W'(STABLE_N);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;
  localparam logic [CAND_W-1:0] CAND_NONE = 3'b100;

`ifdef TILT_NO_REVERSE_EN
  localparam bit NO_REVERSE = 1'b1;
`else
  localparam bit NO_REVERSE = 1'b0;
`endif

  typedef enum logic [1:0] {S_WAIT, S_CAPTURE, S_SUM, S_DECIDE} state_t;

  state_t                  state;
  logic [DIV_W-1:0]        div;
  logic signed [SMP_W-1:0] hist_x [TAPS];
  logic signed [SMP_W-1:0] hist_y [TAPS];
  logic signed [SMP_W-1:0] tilt_x;
  logic signed [SMP_W-1:0] tilt_y;
  logic [1:0]              dir;
  logic                    dir_valid;
  logic                    flat;
  logic [CNT_W-1:0]        stable_cnt;
  logic [CAND_W-1:0]       last_cand;

  logic signed [SUM_W-1:0] sum_x_c;
  logic signed [SUM_W-1:0] sum_y_c;
  logic signed [MAG_W-1:0] ext_x_c;
  logic signed [MAG_W-1:0] ext_y_c;
  logic [MAG_W-1:0]        mag_x_c;
  logic [MAG_W-1:0]        mag_y_c;
  logic [MAG_W-1:0]        mag_dom_c;
  logic [1:0]              dir_cand_c;
  logic                    flat_c;
  logic [CAND_W-1:0]       cand_c;
  logic [CNT_W-1:0]        cnt_next_c;
  logic                    commit_c;

  logic signed [SMP_W-1:0] raw_x_c;
  logic signed [SMP_W-1:0] raw_y_c;

  assign raw_x_c = {bus.iX_H, bus.iX_L};
  assign raw_y_c = {bus.iY_H, bus.iY_L};

  // Window sums, sign-extended to 18 bits so four full-scale samples cannot overflow
  always_comb begin
    sum_x_c = '0;
    sum_y_c = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      sum_x_c = sum_x_c + SUM_W'(hist_x[i]);
      sum_y_c = sum_y_c + SUM_W'(hist_y[i]);
    end
  end

  // Magnitudes carry one extra bit so |-32768| is representable
  always_comb begin
    ext_x_c = MAG_W'(tilt_x);
    ext_y_c = MAG_W'(tilt_y);
    mag_x_c = tilt_x[SMP_W-1] ? -ext_x_c : ext_x_c;
    mag_y_c = tilt_y[SMP_W-1] ? -ext_y_c : ext_y_c;
  end

  // Candidate heading: X wins ties; a zero axis value never clears a nonzero threshold
  always_comb begin
    mag_dom_c  = '0;
    dir_cand_c = DIR_RIGHT;
    flat_c     = 1'b1;
    cand_c     = CAND_NONE;
    if (mag_x_c >= mag_y_c) begin
      mag_dom_c  = mag_x_c;
      dir_cand_c = tilt_x[SMP_W-1] ? DIR_LEFT : DIR_RIGHT;
    end else begin
      mag_dom_c  = mag_y_c;
      dir_cand_c = tilt_y[SMP_W-1] ? DIR_DOWN : DIR_UP;
    end
    flat_c = (mag_dom_c < THRESH_MAG);
    if (!flat_c) begin
      cand_c = {1'b0, dir_cand_c};
    end
    if (NO_REVERSE && !flat_c && (dir_cand_c == (dir ^ 2'b10))) begin
      cand_c = CAND_NONE;
    end
  end

  // Debounce: count repeats of the same candidate, commit once it has been seen STABLE_N times
  always_comb begin
    cnt_next_c = CNT_W'(1);
    commit_c   = 1'b0;
    if (cand_c == last_cand) begin
      cnt_next_c = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
    end
    commit_c = (cand_c != CAND_NONE) && (cand_c[1:0] != dir) && (cnt_next_c >= STABLE_CNT);
  end

  // Sequencer, free-running divider and all registered state
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= S_WAIT;
      div        <= '0;
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_x[i] <= '0;
        hist_y[i] <= '0;
      end
      tilt_x     <= '0;
      tilt_y     <= '0;
      dir        <= INIT_DIR;
      dir_valid  <= 1'b0;
      flat       <= 1'b1;
      stable_cnt <= '0;
      last_cand  <= CAND_NONE;
    end else begin
      dir_valid <= 1'b0;
      div       <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      case (state)
        S_WAIT: begin
          if (div == DIV_LAST) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          hist_x[0] <= raw_x_c;
          hist_y[0] <= raw_y_c;
          for (int i = 1; i < int'(TAPS); i++) begin
            hist_x[i] <= hist_x[i-1];
            hist_y[i] <= hist_y[i-1];
          end
          state <= S_SUM;
        end
        S_SUM: begin
          tilt_x <= SMP_W'(sum_x_c >>> 2);
          tilt_y <= SMP_W'(sum_y_c >>> 2);
          state  <= S_DECIDE;
        end
        S_DECIDE: begin
          flat       <= flat_c;
          stable_cnt <= cnt_next_c;
          last_cand  <= cand_c;
          if (commit_c) begin
            dir       <= cand_c[1:0];
            dir_valid <= 1'b1;
          end
          state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign bus.oDIR       = dir;
  assign bus.oDIR_VALID = dir_valid;
  assign bus.oTILT_X    = tilt_x;
  assign bus.oTILT_Y    = tilt_y;
  assign bus.oFLAT      = flat;

endmodule
